// File: rtl/vga_cmd_pkg.sv
// Shared definitions for the VGA command issuer: opcodes, FSM encoding and the
// packed command layout that travels through the command FIFO.
package vga_cmd_pkg;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_POS    = 3'd1;
  localparam logic [2:0] OP_ATT    = 3'd2;
  localparam logic [2:0] OP_BG     = 3'd3;
  localparam logic [2:0] OP_FSEL   = 3'd4;
  localparam logic [2:0] OP_FWRITE = 3'd5;

  localparam int CMD_W = 45;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_GAP
  } state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  sprite;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        vis;
    logic [1:0]  bg;
    logic [3:0]  fdata;
    logic [10:0] faddr;
  } cmd_t;

  // Change requests must be held for several cycles; every other op is a single-cycle strobe.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op == OP_BG) || (op == OP_FSEL);
  endfunction

endpackage

// File: rtl/vga_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO: rdata always shows the oldest entry
// while empty is low. Push and pop in the same cycle are both honoured.
module vga_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 45
) (
  input  logic         clk_100mhz_buf,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_100mhz_buf) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk_100mhz_buf) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vga_cmd_issuer.sv
// Host-side initiator for the VGA sprite/background/font interface: queues commands
// and replays each as a SETUP / STROBE / GAP sequence, optionally only during vsync.
module vga_cmd_issuer
  import vga_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH       = 8,
  parameter int CHG_HOLD         = 4,
  parameter int VSYNC_GATE       = 1,
  parameter int VSYNC_ACTIVE_LOW = 1
) (
  input  logic        clk_100mhz_buf,
  input  logic        rst,
  // Handshake: a command is accepted on any rising edge where cmd_valid && cmd_ready;
  // cmd_ready depends only on FIFO fullness, never on cmd_valid.
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [4:0]  cmd_sprite,
  input  logic [9:0]  cmd_x,
  input  logic [8:0]  cmd_y,
  input  logic        cmd_vis,
  input  logic [1:0]  cmd_bg,
  input  logic [3:0]  cmd_fdata,
  input  logic [10:0] cmd_faddr,
  input  logic        vsync,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        visable,
  output logic [4:0]  sprite_sel,
  output logic [1:0]  background_sel,
  output logic [3:0]  fwdata,
  output logic [10:0] fwaddr,
  output logic        load_pos,
  output logic        load_att,
  output logic        bchange_active,
  output logic        fchange_active,
  output logic        fwenable,
  output logic        busy,
  output logic        err
);

  localparam int HW = $clog2(CHG_HOLD) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(CHG_HOLD - 1);

  state_t        state;
  logic [2:0]    cur_op;
  logic [HW-1:0] hold_cnt;
  logic          vs_s1, vs_s2, vs_act;
  logic          fifo_full, fifo_empty, pop;
  cmd_t          in_cmd, head;
  logic [CMD_W-1:0] head_bits;

  // vsync comes from the pixel-clock domain, so it is resynchronised before use.
  always_ff @(posedge clk_100mhz_buf) begin
    if (rst) begin
      vs_s1 <= 1'b0;
      vs_s2 <= 1'b0;
    end else begin
      vs_s1 <= vsync;
      vs_s2 <= vs_s1;
    end
  end

  assign vs_act    = (VSYNC_ACTIVE_LOW != 0) ? !vs_s2 : vs_s2;
  assign in_cmd    = {cmd_op, cmd_sprite, cmd_x, cmd_y, cmd_vis, cmd_bg, cmd_fdata, cmd_faddr};
  assign head      = cmd_t'(head_bits);
  assign cmd_ready = !fifo_full;
  assign pop       = (state == ST_IDLE) && !fifo_empty && ((VSYNC_GATE == 0) || vs_act);
  assign busy      = (state != ST_IDLE) || !fifo_empty;

  vga_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(CMD_W)) u_fifo (
    .clk_100mhz_buf (clk_100mhz_buf),
    .rst            (rst),
    .push           (cmd_valid && !fifo_full),
    .pop            (pop),
    .wdata          (in_cmd),
    .rdata          (head_bits),
    .full           (fifo_full),
    .empty          (fifo_empty)
  );

  always_ff @(posedge clk_100mhz_buf) begin
    if (rst) begin
      state          <= ST_IDLE;
      cur_op         <= OP_NOP;
      hold_cnt       <= '0;
      x              <= '0;
      y              <= '0;
      visable        <= 1'b0;
      sprite_sel     <= '0;
      background_sel <= '0;
      fwdata         <= '0;
      fwaddr         <= '0;
      load_pos       <= 1'b0;
      load_att       <= 1'b0;
      bchange_active <= 1'b0;
      fchange_active <= 1'b0;
      fwenable       <= 1'b0;
      err            <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            // Only the fields an op uses are latched; the rest keep their last value.
            case (head.op)
              OP_POS: begin
                sprite_sel <= head.sprite;
                x          <= head.x;
                y          <= head.y;
              end
              OP_ATT: begin
                sprite_sel <= head.sprite;
                visable    <= head.vis;
              end
              OP_BG:     background_sel <= head.bg;
              OP_FWRITE: begin
                fwdata <= head.fdata;
                fwaddr <= head.faddr;
              end
              default: ;
            endcase
            cur_op <= head.op;
            if (head.op > OP_FWRITE) err <= 1'b1;
            else if (head.op != OP_NOP) state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          state    <= ST_STROBE;
          hold_cnt <= '0;
          case (cur_op)
            OP_POS:    load_pos       <= 1'b1;
            OP_ATT:    load_att       <= 1'b1;
            OP_BG:     bchange_active <= 1'b1;
            OP_FSEL:   fchange_active <= 1'b1;
            OP_FWRITE: fwenable       <= 1'b1;
            default: ;
          endcase
        end
        ST_STROBE: begin
          if (!is_long_op(cur_op) || (hold_cnt == HOLD_LAST)) begin
            load_pos       <= 1'b0;
            load_att       <= 1'b0;
            bchange_active <= 1'b0;
            fchange_active <= 1'b0;
            fwenable       <= 1'b0;
            state          <= ST_GAP;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_GAP:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_cmd_issuer.sv
// Directed bench for vga_cmd_issuer: vsync gating, strobe timing, FIFO fill/drain,
// strobe exclusivity, illegal opcodes and mid-command reset.
module tb_vga_cmd_issuer;
  import vga_cmd_pkg::*;

  logic        clk_100mhz_buf = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [4:0]  cmd_sprite = '0;
  logic [9:0]  cmd_x = '0;
  logic [8:0]  cmd_y = '0;
  logic        cmd_vis = 1'b0;
  logic [1:0]  cmd_bg = '0;
  logic [3:0]  cmd_fdata = '0;
  logic [10:0] cmd_faddr = '0;
  logic        vsync = 1'b1;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        visable;
  logic [4:0]  sprite_sel;
  logic [1:0]  background_sel;
  logic [3:0]  fwdata;
  logic [10:0] fwaddr;
  logic        load_pos, load_att, bchange_active, fchange_active, fwenable;
  logic        busy, err;

  int errors = 0;
  int checks = 0;
  logic [14:0] exp_q [$];

  vga_cmd_issuer dut (
    .clk_100mhz_buf (clk_100mhz_buf),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_sprite     (cmd_sprite),
    .cmd_x          (cmd_x),
    .cmd_y          (cmd_y),
    .cmd_vis        (cmd_vis),
    .cmd_bg         (cmd_bg),
    .cmd_fdata      (cmd_fdata),
    .cmd_faddr      (cmd_faddr),
    .vsync          (vsync),
    .x              (x),
    .y              (y),
    .visable        (visable),
    .sprite_sel     (sprite_sel),
    .background_sel (background_sel),
    .fwdata         (fwdata),
    .fwaddr         (fwaddr),
    .load_pos       (load_pos),
    .load_att       (load_att),
    .bchange_active (bchange_active),
    .fchange_active (fchange_active),
    .fwenable       (fwenable),
    .busy           (busy),
    .err            (err)
  );

  always #5 clk_100mhz_buf = ~clk_100mhz_buf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [4:0] strb();
    return {load_pos, load_att, bchange_active, fchange_active, fwenable};
  endfunction

  // Called at a negedge; the command is accepted on the following posedge.
  task automatic push(input logic [2:0] op, input logic [4:0] spr, input logic [9:0] px,
                      input logic [8:0] py, input logic vis, input logic [1:0] bg,
                      input logic [3:0] fd, input logic [10:0] fa);
    cmd_op = op; cmd_sprite = spr; cmd_x = px; cmd_y = py;
    cmd_vis = vis; cmd_bg = bg; cmd_fdata = fd; cmd_faddr = fa;
    cmd_valid = 1'b1;
    @(negedge clk_100mhz_buf);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int n, gap, bg_cnt, fs_cnt, multi, last_bg, first_fs, err_cnt, att_cnt;
    logic [14:0] e;
    logic        att_vis;
    logic [4:0]  att_spr;

    // Reset
    repeat (3) @(negedge clk_100mhz_buf);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", strb(), 0);
    chk("rst_x", x, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk_100mhz_buf);

    // POS held off while vsync inactive (active-low input held high)
    push(OP_POS, 5'd3, 10'd320, 9'd200, 1'b0, 2'd0, 4'd0, 11'd0);
    n = 0;
    repeat (10) begin
      if (strb() != 0) n++;
      @(negedge clk_100mhz_buf);
    end
    chk("gate_no_strobe", n, 0);
    chk("gate_busy", busy, 1);
    chk("gate_x_unchanged", x, 0);
    vsync = 1'b0;
    for (int i = 0; i < 12 && x !== 10'd320; i++) @(negedge clk_100mhz_buf);
    chk("pos_x", x, 320);
    chk("pos_y", y, 200);
    chk("pos_sprite", sprite_sel, 3);
    chk("pos_setup_nostrobe", strb(), 0);
    @(negedge clk_100mhz_buf);
    chk("pos_strobe", strb(), 5'b10000);
    @(negedge clk_100mhz_buf);
    chk("pos_gap", strb(), 0);
    chk("pos_x_hold", x, 320);
    @(negedge clk_100mhz_buf);
    chk("pos_done_busy", busy, 0);

    // BG: 4-cycle hold then a gap
    push(OP_BG, 5'd0, 10'd0, 9'd0, 1'b0, 2'd2, 4'd0, 11'd0);
    for (int i = 0; i < 12 && background_sel !== 2'd2; i++) @(negedge clk_100mhz_buf);
    chk("bg_sel", background_sel, 2);
    chk("bg_setup_nostrobe", strb(), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_100mhz_buf);
      chk("bg_hold", strb(), 5'b00100);
    end
    @(negedge clk_100mhz_buf);
    chk("bg_gap", strb(), 0);
    chk("bg_x_untouched", x, 320);

    // Fill the FIFO with 8 FWRITEs while gated, then drain
    vsync = 1'b1;
    repeat (3) @(negedge clk_100mhz_buf);
    for (int i = 0; i < 8; i++) begin
      push(OP_FWRITE, 5'd0, 10'd0, 9'd0, 1'b0, 2'd0, 4'(i) ^ 4'hA, 11'(i * 100 + 7));
      exp_q.push_back({11'(i * 100 + 7), 4'(i) ^ 4'hA});
    end
    chk("fifo_full_ready", cmd_ready, 0);
    repeat (2) @(negedge clk_100mhz_buf);
    chk("fifo_full_no_strobe", strb(), 0);
    vsync = 1'b0;
    for (int i = 0; i < 8; i++) begin
      gap = 0;
      do begin
        @(negedge clk_100mhz_buf);
        gap++;
      end while (!fwenable && gap < 12);
      chk("fw_pulse_seen", fwenable, 1);
      if (i == 0) chk("fw_ready_back", cmd_ready, 1);
      else        chk("fw_spacing", gap, 4);
      e = exp_q.pop_front();
      chk("fw_addr", fwaddr, e[14:4]);
      chk("fw_data", fwdata, e[3:0]);
    end
    @(negedge clk_100mhz_buf);
    chk("fw_single_cycle", fwenable, 0);
    repeat (3) @(negedge clk_100mhz_buf);

    // BG then FSEL back-to-back: disjoint windows
    push(OP_BG, 5'd0, 10'd0, 9'd0, 1'b0, 2'd1, 4'd0, 11'd0);
    push(OP_FSEL, 5'd0, 10'd0, 9'd0, 1'b0, 2'd0, 4'd0, 11'd0);
    bg_cnt = 0; fs_cnt = 0; multi = 0; last_bg = -1; first_fs = -1;
    for (int t = 0; t < 30; t++) begin
      if ($countones(strb()) > 1) multi++;
      if (bchange_active) begin bg_cnt++; last_bg = t; end
      if (fchange_active) begin fs_cnt++; if (first_fs < 0) first_fs = t; end
      @(negedge clk_100mhz_buf);
    end
    chk("excl_overlap", multi, 0);
    chk("excl_bg_cnt", bg_cnt, 4);
    chk("excl_fs_cnt", fs_cnt, 4);
    chk("excl_gap", first_fs - last_bg - 1, 3);
    chk("excl_bg_sel", background_sel, 1);

    // Illegal opcode then ATT
    push(3'd7, 5'd9, 10'd0, 9'd0, 1'b0, 2'd0, 4'd0, 11'd0);
    push(OP_ATT, 5'd5, 10'd0, 9'd0, 1'b1, 2'd0, 4'd0, 11'd0);
    err_cnt = 0; att_cnt = 0; att_vis = 1'b0; att_spr = '0;
    for (int t = 0; t < 20; t++) begin
      if (err) err_cnt++;
      if (load_att) begin att_cnt++; att_vis = visable; att_spr = sprite_sel; end
      @(negedge clk_100mhz_buf);
    end
    chk("ill_err_cnt", err_cnt, 1);
    chk("att_cnt", att_cnt, 1);
    chk("att_vis", att_vis, 1);
    chk("att_sprite", att_spr, 5);

    // Reset during a BG hold with three commands still queued
    vsync = 1'b1;
    repeat (3) @(negedge clk_100mhz_buf);
    push(OP_BG, 5'd0, 10'd0, 9'd0, 1'b0, 2'd3, 4'd0, 11'd0);
    push(OP_POS, 5'd7, 10'd100, 9'd50, 1'b0, 2'd0, 4'd0, 11'd0);
    push(OP_ATT, 5'd2, 10'd0, 9'd0, 1'b1, 2'd0, 4'd0, 11'd0);
    push(OP_FWRITE, 5'd0, 10'd0, 9'd0, 1'b0, 2'd0, 4'd6, 11'd99);
    vsync = 1'b0;
    for (int i = 0; i < 20 && !bchange_active; i++) @(negedge clk_100mhz_buf);
    chk("mid_bg_active", bchange_active, 1);
    @(negedge clk_100mhz_buf);
    rst = 1'b1;
    @(negedge clk_100mhz_buf);
    chk("mid_rst_strobes", strb(), 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_x", x, 0);
    @(negedge clk_100mhz_buf);
    rst = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge clk_100mhz_buf);
      if (strb() != 0) n++;
    end
    chk("post_rst_no_strobe", n, 0);
    chk("post_rst_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
